// File: rtl/alu_fp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_fp_pkg
// Brief   : FP32 field layout, divider state encoding, constants and
//           operand classifiers shared by the ALU floating-point units.
// Rev     : 1.0  initial release
// ============================================================================
package alu_fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam int          EXP_BIAS   = 127;

  // Denormals are flushed: any operand with a zero exponent field counts as zero.
  function automatic logic fp_is_zero(input fp32_t x);
    return (x.exp == 8'h00);
  endfunction

  function automatic logic fp_is_inf(input fp32_t x);
    return (x.exp == FP_EXP_MAX) && (x.mant == 23'h0);
  endfunction

  function automatic logic fp_is_nan(input fp32_t x);
    return (x.exp == FP_EXP_MAX) && (x.mant != 23'h0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_div_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_div_if
// Brief   : start/done handshake and operand/result bus of the FP32 divider.
// Rev     : 1.0  initial release
// ============================================================================
interface alu_div_if;

  logic        start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] Resultado;
  logic        busy;
  logic        done;

  modport master (
    output start,
    output dataA,
    output dataB,
    input  Resultado,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  dataA,
    input  dataB,
    output Resultado,
    output busy,
    output done
  );

endinterface
`default_nettype wire

// File: rtl/div_mant_restoring.sv
`default_nettype none
// ============================================================================
// Module  : div_mant_restoring
// Brief   : restoring mantissa divider, one quotient bit per step.
// Rev     : 1.0  initial release
// ============================================================================
module div_mant_restoring #(
  parameter int QBITS = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [23:0]      ma,
  input  logic [23:0]      mb,
  output logic [QBITS-1:0] q,
  output logic [25:0]      r
);

  logic [25:0]      r_rem;
  logic [23:0]      r_mb;
  logic [QBITS-1:0] r_quo;

  logic             w_ge;
  logic [24:0]      w_diff;

  // The remainder stays below 2*mb, so after a subtraction it fits in 25 bits.
  assign w_ge   = (r_rem >= {2'b00, r_mb});
  assign w_diff = r_rem[24:0] - {1'b0, r_mb};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem <= '0;
      r_mb  <= '0;
      r_quo <= '0;
    end else if (load) begin
      r_rem <= {2'b00, ma};
      r_mb  <= mb;
      r_quo <= '0;
    end else if (step) begin
      r_quo <= {r_quo[QBITS-2:0], w_ge};
      r_rem <= w_ge ? {w_diff, 1'b0} : {r_rem[24:0], 1'b0};
    end
  end

  assign q = r_quo;
  assign r = r_rem;

endmodule
`default_nettype wire

// File: rtl/alu_div.sv
`default_nettype none
// ============================================================================
// Module  : alu_div
// Brief   : iterative FP32 divider Resultado = dataA / dataB, fixed latency,
//           truncating, start/busy/done handshake.
// Rev     : 1.0  initial release
// ============================================================================
module alu_div #(
  parameter int QBITS    = 25,
  parameter int EXP_BIAS = alu_fp_pkg::EXP_BIAS
) (
  input  logic     clk,
  input  logic     reset,
  alu_div_if.slave bus
);

  import alu_fp_pkg::*;

  localparam logic [1:0] c_st_idle = IDLE;
  localparam logic [1:0] c_st_div  = DIV;
  localparam logic [1:0] c_st_norm = NORM;
  localparam logic [1:0] c_st_done = DONE;
  localparam logic [4:0] c_last    = 5'(QBITS - 1);

  logic [1:0]        r_state;
  logic [4:0]        r_cnt;
  fp32_t             r_opa;
  fp32_t             r_opb;
  logic signed [9:0] r_exp;
  logic [31:0]       r_result;
  logic              r_done;

  logic              w_load;
  logic              w_step;
  logic [QBITS-1:0]  w_q;
  logic [25:0]       w_rem_unused;
  logic signed [9:0] w_exp_cap;
  logic signed [9:0] w_exp_n;
  logic [22:0]       w_mant;
  logic              w_sign;
  logic              w_nan;
  logic              w_inf;
  logic              w_zero;
  logic [31:0]       w_res;

  assign w_load = (r_state == c_st_idle) && bus.start;
  assign w_step = (r_state == c_st_div);

  div_mant_restoring #(
    .QBITS (QBITS)
  ) u_mant (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .step  (w_step),
    .ma    ({1'b1, bus.dataA[22:0]}),
    .mb    ({1'b1, bus.dataB[22:0]}),
    .q     (w_q),
    .r     (w_rem_unused)
  );

  assign w_exp_cap = $signed({2'b00, bus.dataA[30:23]})
                   - $signed({2'b00, bus.dataB[30:23]})
                   + 10'(EXP_BIAS);

  // Quotient lies in [0.5, 2): the top bit selects which window is the mantissa.
  assign w_exp_n = w_q[QBITS-1] ? r_exp : (r_exp - 10'sd1);
  assign w_mant  = w_q[QBITS-1] ? w_q[QBITS-2:QBITS-24] : w_q[QBITS-3:QBITS-25];
  assign w_sign  = r_opa.sign ^ r_opb.sign;

  assign w_nan  = fp_is_nan(r_opa) || fp_is_nan(r_opb)
               || (fp_is_zero(r_opa) && fp_is_zero(r_opb))
               || (fp_is_inf(r_opa)  && fp_is_inf(r_opb));
  assign w_inf  = fp_is_inf(r_opa)  || fp_is_zero(r_opb);
  assign w_zero = fp_is_zero(r_opa) || fp_is_inf(r_opb);

  always_comb begin
    w_res = {w_sign, w_exp_n[7:0], w_mant};
    if (w_nan) begin
      w_res = FP_QNAN;
    end else if (w_inf || (w_exp_n >= 10'sd255)) begin
      w_res = {w_sign, FP_EXP_MAX, 23'h0};
    end else if (w_zero || (w_exp_n <= 10'sd0)) begin
      w_res = {w_sign, 31'h0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= c_st_idle;
      r_cnt    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_exp    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (bus.start) begin
            r_opa   <= bus.dataA;
            r_opb   <= bus.dataB;
            r_exp   <= w_exp_cap;
            r_cnt   <= '0;
            r_state <= c_st_div;
          end
        end
        c_st_div: begin
          if (r_cnt == c_last) begin
            r_state <= c_st_norm;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        c_st_norm: begin
          r_result <= w_res;
          r_state  <= c_st_done;
        end
        c_st_done: begin
          r_done  <= 1'b1;
          r_state <= c_st_idle;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign bus.Resultado = r_result;
  assign bus.busy      = (r_state != c_st_idle);
  assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_div.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_div
// Brief   : directed self-checking bench for the FP32 divider.
// Rev     : 1.0  initial release
// ============================================================================
module tb_alu_div;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  alu_div_if bus_if ();

  alu_div dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] va [10] = '{32'h3F800000, 32'hC1200000, 32'h3F800000, 32'h00000000,
                           32'h7F800000, 32'h80000000, 32'h7F000000, 32'h00800000,
                           32'h7F800001, 32'h40400000};
  logic [31:0] vb [10] = '{32'h40400000, 32'h40A00000, 32'h00000000, 32'h00000000,
                           32'h7F800000, 32'h40000000, 32'h3E800000, 32'h40000000,
                           32'h3F800000, 32'hBF800000};
  logic [31:0] vr [10] = '{32'h3EAAAAAA, 32'hC0000000, 32'h7F800000, 32'h7FC00000,
                           32'h7FC00000, 32'h80000000, 32'h7F800000, 32'h00000000,
                           32'h7FC00000, 32'hC0400000};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, expv);
    end
  endtask

  // now=1 raises start in the current (done) cycle for a back-to-back issue.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input bit now);
    int lat;
    lat = 0;
    if (!now) @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.dataA = a;
    bus_if.dataB = b;
    @(negedge clk);
    bus_if.start = 1'b0;
    chk({tag, "_busy"}, {31'b0, bus_if.busy}, 32'd1);
    while (!bus_if.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd27);
    chk({tag, "_res"}, bus_if.Resultado, expv);
  endtask

  initial begin
    int lat;
    int ndone;
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    bus_if.start = 1'b0;
    bus_if.dataA = '0;
    bus_if.dataB = '0;

    #1;
    chk("rst_res",  bus_if.Resultado, 32'h0);
    chk("rst_busy", {31'b0, bus_if.busy}, 32'd0);
    chk("rst_done", {31'b0, bus_if.done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op("t1", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
    @(negedge clk);
    chk("t1_pulse", {31'b0, bus_if.done}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("v%0d", i), va[i], vb[i], vr[i], 1'b0);
    end

    // Start pulsed mid-DIV must be ignored.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.dataA = 32'h3F800000;
    bus_if.dataB = 32'h40400000;
    @(negedge clk);
    bus_if.start = 1'b0;
    lat = 0;
    while (!bus_if.done && lat < 40) begin
      @(negedge clk);
      lat++;
      bus_if.start = (lat == 5);
      if (lat == 5) begin
        bus_if.dataA = 32'h7F800000;
        bus_if.dataB = 32'h00000000;
      end
    end
    bus_if.start = 1'b0;
    chk("t5_lat", 32'(lat), 32'd27);
    chk("t5_res", bus_if.Resultado, 32'h3EAAAAAA);
    do_op("t5b", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b1);

    // Asynchronous reset in the middle of DIV.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.dataA = 32'hC1200000;
    bus_if.dataB = 32'h40A00000;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_busy", {31'b0, bus_if.busy}, 32'd0);
    chk("t6_done", {31'b0, bus_if.done}, 32'd0);
    chk("t6_res",  bus_if.Resultado, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (35) begin
      @(negedge clk);
      if (bus_if.done) ndone++;
    end
    chk("t6_nodone", 32'(ndone), 32'd0);
    do_op("t6b", 32'hC1200000, 32'h40A00000, 32'hC0000000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
